vending_buyer: RTL and testbench

- Initiator-side transactor for the vendingMachine coin/item protocol. It accepts a purchase order (item plus coin counts) over a valid/ready port and drives the machine's coin and item inputs for one request.
- It then waits for the machine to finish and captures the returned change and item.
- It checks the change against the item cost and returns the result over a valid/ready response port.
- Used as the stimulus/check front-end in vending testbenches and in multi-buyer system models.

---
 rtl/vending_buyer_if.sv | 37 +++
 rtl/vending_buyer.sv | 212 +++++++++++++++++++++
 tb/tb_vending_buyer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_buyer_if.sv
// rtl/vending_buyer_if.sv - order/response handshake bundle for vending_buyer
//
// Order side:    req_valid, req_ready, req_item, req_ntd50/10/5/1
// Response side: rsp_valid, rsp_ready, rsp_item, rsp_paid, rsp_change,
//                rsp_error, rsp_timeout
// slave modport is the buyer; master modport is whoever issues orders.
interface vending_buyer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_item;
    logic [1:0] req_ntd50;
    logic [1:0] req_ntd10;
    logic [1:0] req_ntd5;
    logic [1:0] req_ntd1;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_item;
    logic [7:0] rsp_paid;
    logic [8:0] rsp_change;
    logic       rsp_error;
    logic       rsp_timeout;

    modport slave (
        input  req_valid, req_item, req_ntd50, req_ntd10, req_ntd5, req_ntd1,
        output req_ready,
        output rsp_valid, rsp_item, rsp_paid, rsp_change, rsp_error, rsp_timeout,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_item, req_ntd50, req_ntd10, req_ntd5, req_ntd1,
        input  req_ready,
        input  rsp_valid, rsp_item, rsp_paid, rsp_change, rsp_error, rsp_timeout,
        output rsp_ready
    );
endinterface

// File: rtl/vending_buyer.sv
// rtl/vending_buyer.sv - initiator-side transactor for the vending machine protocol
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   bus            vending_buyer_if.slave: order in, checked response out
//   coinInNTD_*    coin counts driven to the machine (one-cycle pulse)
//   itemTypeIn     item request driven to the machine (one-cycle pulse)
//   coinOutNTD_*   change returned by the machine
//   itemTypeOut    item delivered by the machine
//   serviceTypeOut machine state: 00 OFF, 01 ON, 10 BUSY
module vending_buyer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    vending_buyer_if.slave  bus,
    output logic [1:0]      coinInNTD_50,
    output logic [1:0]      coinInNTD_10,
    output logic [1:0]      coinInNTD_5,
    output logic [1:0]      coinInNTD_1,
    output logic [1:0]      itemTypeIn,
    input  logic [2:0]      coinOutNTD_50,
    input  logic [2:0]      coinOutNTD_10,
    input  logic [2:0]      coinOutNTD_5,
    input  logic [2:0]      coinOutNTD_1,
    input  logic [1:0]      itemTypeOut,
    input  logic [1:0]      serviceTypeOut
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_ON  = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT_OFF = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    localparam logic [1:0] SVC_OFF = 2'b00;
    localparam logic [1:0] SVC_ON  = 2'b01;

    // Counter value on the last permitted waiting cycle; the wait aborts
    // after exactly TIMEOUT_CYCLES cycles in WAIT_ON or WAIT_OFF.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state;
    logic [7:0] cnt;

    logic [1:0] ord_item;
    logic [1:0] ord_n50;
    logic [1:0] ord_n10;
    logic [1:0] ord_n5;
    logic [1:0] ord_n1;
    logic [7:0] paid;

    logic       rsp_valid;
    logic [1:0] rsp_item;
    logic [8:0] rsp_change;
    logic       rsp_error;
    logic       rsp_timeout;

    logic [7:0] paid_in;
    logic [8:0] change_in;
    logic [8:0] change_exp;
    logic       item_bad;
    logic       change_bad;

    function automatic logic [4:0] item_cost(input logic [1:0] item);
        case (item)
            2'b01:   item_cost = 5'd8;
            2'b10:   item_cost = 5'd15;
            2'b11:   item_cost = 5'd22;
            default: item_cost = 5'd0;
        endcase
    endfunction

    // Max 198, fits 8 bits.
    assign paid_in = {6'd0, bus.req_ntd50} * 8'd50
                   + {6'd0, bus.req_ntd10} * 8'd10
                   + {6'd0, bus.req_ntd5}  * 8'd5
                   + {6'd0, bus.req_ntd1};

    // Max 462, fits 9 bits without wrapping.
    assign change_in = {6'd0, coinOutNTD_50} * 9'd50
                     + {6'd0, coinOutNTD_10} * 9'd10
                     + {6'd0, coinOutNTD_5}  * 9'd5
                     + {6'd0, coinOutNTD_1};

    // When paid < cost the difference is negative (490..511 as 9 bits), which
    // can never equal a legal change value, so the compare flags it.
    assign change_exp = {1'b0, paid} - {4'd0, item_cost(itemTypeOut)};
    assign item_bad   = (itemTypeOut != 2'b00) && (itemTypeOut != ord_item);
    assign change_bad = (change_in != change_exp);

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_item    = rsp_item;
    assign bus.rsp_paid    = paid;
    assign bus.rsp_change  = rsp_change;
    assign bus.rsp_error   = rsp_error;
    assign bus.rsp_timeout = rsp_timeout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            ord_item     <= 2'd0;
            ord_n50      <= 2'd0;
            ord_n10      <= 2'd0;
            ord_n5       <= 2'd0;
            ord_n1       <= 2'd0;
            paid         <= 8'd0;
            coinInNTD_50 <= 2'd0;
            coinInNTD_10 <= 2'd0;
            coinInNTD_5  <= 2'd0;
            coinInNTD_1  <= 2'd0;
            itemTypeIn   <= 2'd0;
            rsp_valid    <= 1'b0;
            rsp_item     <= 2'd0;
            rsp_change   <= 9'd0;
            rsp_error    <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        ord_item <= bus.req_item;
                        ord_n50  <= bus.req_ntd50;
                        ord_n10  <= bus.req_ntd10;
                        ord_n5   <= bus.req_ntd5;
                        ord_n1   <= bus.req_ntd1;
                        paid     <= paid_in;
                        if (bus.req_item == 2'b00) begin
                            // Nothing to buy: answer at once with an error.
                            state       <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_error   <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_item    <= 2'd0;
                            rsp_change  <= 9'd0;
                        end else begin
                            state <= ST_WAIT_ON;
                            cnt   <= 8'd0;
                        end
                    end
                end

                ST_WAIT_ON: begin
                    if (serviceTypeOut == SVC_ON) begin
                        coinInNTD_50 <= ord_n50;
                        coinInNTD_10 <= ord_n10;
                        coinInNTD_5  <= ord_n5;
                        coinInNTD_1  <= ord_n1;
                        itemTypeIn   <= ord_item;
                        state        <= ST_ISSUE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_error   <= 1'b0;
                        rsp_item    <= 2'd0;
                        rsp_change  <= 9'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                ST_ISSUE: begin
                    // The request is a single-cycle pulse; if the machine left
                    // ON meanwhile it did not take it, so wait for ON again.
                    coinInNTD_50 <= 2'd0;
                    coinInNTD_10 <= 2'd0;
                    coinInNTD_5  <= 2'd0;
                    coinInNTD_1  <= 2'd0;
                    itemTypeIn   <= 2'd0;
                    cnt          <= 8'd0;
                    state        <= (serviceTypeOut == SVC_ON) ? ST_WAIT_OFF : ST_WAIT_ON;
                end

                ST_WAIT_OFF: begin
                    if (serviceTypeOut == SVC_OFF) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_item    <= itemTypeOut;
                        rsp_change  <= change_in;
                        rsp_error   <= item_bad | change_bad;
                        rsp_timeout <= 1'b0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_error   <= 1'b0;
                        rsp_item    <= 2'd0;
                        rsp_change  <= 9'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_error   <= 1'b0;
                        rsp_timeout <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_buyer.sv
// tb/tb_vending_buyer.sv - scoreboard bench for vending_buyer with a behavioural machine model
module tb_vending_buyer;

    localparam logic [1:0] SVC_OFF  = 2'b00;
    localparam logic [1:0] SVC_ON   = 2'b01;
    localparam logic [1:0] SVC_BUSY = 2'b10;

    logic clk = 1'b0;
    logic reset = 1'b0;

    vending_buyer_if bus();

    logic [1:0] coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn;
    logic [2:0] coinOutNTD_50 = 3'd0;
    logic [2:0] coinOutNTD_10 = 3'd0;
    logic [2:0] coinOutNTD_5  = 3'd0;
    logic [2:0] coinOutNTD_1  = 3'd0;
    logic [1:0] itemTypeOut    = 2'd0;
    logic [1:0] serviceTypeOut = SVC_ON;

    vending_buyer #(.TIMEOUT_CYCLES(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .coinInNTD_50   (coinInNTD_50),
        .coinInNTD_10   (coinInNTD_10),
        .coinInNTD_5    (coinInNTD_5),
        .coinInNTD_1    (coinInNTD_1),
        .itemTypeIn     (itemTypeIn),
        .coinOutNTD_50  (coinOutNTD_50),
        .coinOutNTD_10  (coinOutNTD_10),
        .coinOutNTD_5   (coinOutNTD_5),
        .coinOutNTD_1   (coinOutNTD_1),
        .itemTypeOut    (itemTypeOut),
        .serviceTypeOut (serviceTypeOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] item;
        logic [7:0] paid;
        logic [8:0] change;
        logic       error;
        logic       timeout;
    } rsp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    rsp_t exp_q[$];
    chk_t chk_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cyc = 0;

    // Machine model controls (stimulus writes, model reads).
    int         m_mode = 0;   // 0 normal, 1 stuck BUSY after a request, 2 stuck OFF
    int         m_gen  = 0;   // bump to restart the model from its idle phase
    logic [1:0] ret_item = 2'd0;
    logic [2:0] ret_c50 = 3'd0, ret_c10 = 3'd0, ret_c5 = 3'd0, ret_c1 = 3'd0;

    // Model observations (model writes, stimulus reads).
    int issue_cycles = 0;
    int issue_cyc    = 0;

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        logic prev_valid;
        chk_t c;
        rsp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check(c.name, c.act, c.exp);
            end
            if (bus.rsp_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_item",    int'(bus.rsp_item),    int'(e.item));
                    check("rsp_paid",    int'(bus.rsp_paid),    int'(e.paid));
                    check("rsp_change",  int'(bus.rsp_change),  int'(e.change));
                    check("rsp_error",   int'(bus.rsp_error),   int'(e.error));
                    check("rsp_timeout", int'(bus.rsp_timeout), int'(e.timeout));
                end
            end
        end
    end

    // ---------------- vending machine model ----------------
    initial begin : machine
        int phase;
        int busy_left;
        int seen_gen;
        phase = 0;
        busy_left = 0;
        seen_gen = 0;
        forever begin
            @(negedge clk);
            if (itemTypeIn != 2'd0) issue_cycles++;
            if (seen_gen != m_gen) begin
                seen_gen = m_gen;
                phase = 0;
            end
            if (m_mode == 2) begin
                serviceTypeOut = SVC_OFF;
                {coinOutNTD_50, coinOutNTD_10, coinOutNTD_5, coinOutNTD_1} = 12'd0;
                itemTypeOut = 2'd0;
                phase = 0;
            end else begin
                case (phase)
                    0: begin
                        serviceTypeOut = SVC_ON;
                        {coinOutNTD_50, coinOutNTD_10, coinOutNTD_5, coinOutNTD_1} = 12'd0;
                        itemTypeOut = 2'd0;
                        if (itemTypeIn != 2'd0) begin
                            phase = 1;
                            issue_cyc = cyc;
                        end
                    end
                    1: begin
                        // Request latched at the edge after it was seen.
                        serviceTypeOut = SVC_BUSY;
                        busy_left = 3;
                        phase = (m_mode == 1) ? 9 : 2;
                    end
                    2: begin
                        busy_left--;
                        if (busy_left == 0) begin
                            serviceTypeOut = SVC_OFF;
                            coinOutNTD_50 = ret_c50;
                            coinOutNTD_10 = ret_c10;
                            coinOutNTD_5  = ret_c5;
                            coinOutNTD_1  = ret_c1;
                            itemTypeOut   = ret_item;
                            phase = 3;
                        end
                    end
                    3: begin
                        serviceTypeOut = SVC_ON;
                        {coinOutNTD_50, coinOutNTD_10, coinOutNTD_5, coinOutNTD_1} = 12'd0;
                        itemTypeOut = 2'd0;
                        phase = 0;
                    end
                    default: serviceTypeOut = SVC_BUSY;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_chk(input string name, input int act, input int exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_rsp(input logic [1:0] item, input logic [7:0] paid,
                              input logic [8:0] change, input logic error,
                              input logic timeout);
        rsp_t r;
        r.item = item;
        r.paid = paid;
        r.change = change;
        r.error = error;
        r.timeout = timeout;
        exp_q.push_back(r);
    endtask

    task automatic set_ret(input logic [1:0] item, input logic [2:0] c50,
                           input logic [2:0] c10, input logic [2:0] c5,
                           input logic [2:0] c1);
        ret_item = item;
        ret_c50 = c50;
        ret_c10 = c10;
        ret_c5 = c5;
        ret_c1 = c1;
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] item, input logic [1:0] n50,
                        input logic [1:0] n10, input logic [1:0] n5,
                        input logic [1:0] n1);
        int i;
        bus.req_item  = item;
        bus.req_ntd50 = n50;
        bus.req_ntd10 = n10;
        bus.req_ntd5  = n5;
        bus.req_ntd1  = n1;
        bus.req_valid = 1'b1;
        i = 0;
        while (!bus.req_ready && i < 300) begin
            @(negedge clk);
            i++;
        end
        push_chk("req_accept_wait", int'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        push_chk(name, exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int i;
        bus.req_valid = 1'b0;
        bus.req_item  = 2'd0;
        bus.req_ntd50 = 2'd0;
        bus.req_ntd10 = 2'd0;
        bus.req_ntd5  = 2'd0;
        bus.req_ntd1  = 2'd0;
        bus.rsp_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        push_chk("reset_req_ready",  int'(bus.req_ready), 1);
        push_chk("reset_rsp_valid",  int'(bus.rsp_valid), 0);
        push_chk("reset_rsp_paid",   int'(bus.rsp_paid), 0);
        push_chk("reset_rsp_change", int'(bus.rsp_change), 0);
        push_chk("reset_rsp_error",  int'(bus.rsp_error), 0);
        push_chk("reset_item_in",    int'(itemTypeIn), 0);
        push_chk("reset_coin_in",    int'({coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1}), 0);
        reset = 1'b1;
        @(negedge clk);
        push_chk("req_ready_after_reset", int'(bus.req_ready), 1);

        // A for 10: change 2, one-cycle request pulse
        set_ret(2'b01, 3'd0, 3'd0, 3'd0, 3'd2);
        base = issue_cycles;
        expect_rsp(2'b01, 8'd10, 9'd2, 1'b0, 1'b0);
        send(2'b01, 2'd0, 2'd1, 2'd0, 2'd0);
        drain("drain_a");
        push_chk("issue_pulse_cycles", issue_cycles - base, 1);

        // C with 10 only: nothing delivered, full refund
        set_ret(2'b00, 3'd0, 3'd1, 3'd0, 3'd0);
        expect_rsp(2'b00, 8'd10, 9'd10, 1'b0, 1'b0);
        send(2'b11, 2'd0, 2'd1, 2'd0, 2'd0);
        drain("drain_c_short");

        // B for 50, faulty change 34 instead of 35
        set_ret(2'b10, 3'd0, 3'd3, 3'd0, 3'd4);
        expect_rsp(2'b10, 8'd50, 9'd34, 1'b1, 1'b0);
        send(2'b10, 2'd1, 2'd0, 2'd0, 2'd0);
        drain("drain_b_bad");

        // Wrong item delivered although change fits that item
        set_ret(2'b10, 3'd0, 3'd0, 3'd1, 3'd0);
        expect_rsp(2'b10, 8'd20, 9'd5, 1'b1, 1'b0);
        send(2'b01, 2'd0, 2'd2, 2'd0, 2'd0);
        drain("drain_wrong_item");

        // Maximum paid 198, C, change 176
        set_ret(2'b11, 3'd3, 3'd2, 3'd1, 3'd1);
        expect_rsp(2'b11, 8'd198, 9'd176, 1'b0, 1'b0);
        send(2'b11, 2'd3, 2'd3, 2'd3, 2'd3);
        drain("drain_max_paid");

        // Maximum change 462, no wrap
        set_ret(2'b00, 3'd7, 3'd7, 3'd7, 3'd7);
        expect_rsp(2'b00, 8'd10, 9'd462, 1'b1, 1'b0);
        send(2'b01, 2'd0, 2'd1, 2'd0, 2'd0);
        drain("drain_max_change");

        // Order for no item
        expect_rsp(2'b00, 8'd8, 9'd0, 1'b1, 1'b0);
        send(2'b00, 2'd0, 2'd0, 2'd1, 2'd3);
        drain("drain_none");

        // Machine stuck BUSY: timeout 64 cycles after entering WAIT_OFF
        m_mode = 1;
        expect_rsp(2'b00, 8'd10, 9'd0, 1'b0, 1'b1);
        send(2'b01, 2'd0, 2'd1, 2'd0, 2'd0);
        drain("drain_timeout_off");
        push_chk("timeout_latency", rise_cyc - issue_cyc, 65);
        m_mode = 0;
        m_gen++;
        repeat (2) @(negedge clk);

        // Machine stuck OFF: timeout in WAIT_ON
        m_mode = 2;
        expect_rsp(2'b00, 8'd1, 9'd0, 1'b0, 1'b1);
        send(2'b01, 2'd0, 2'd0, 2'd0, 2'd1);
        drain("drain_timeout_on");
        m_mode = 0;
        m_gen++;
        repeat (2) @(negedge clk);

        // Back-pressure with a second order waiting
        set_ret(2'b01, 3'd0, 3'd0, 3'd0, 3'd2);
        bus.rsp_ready = 1'b0;
        expect_rsp(2'b01, 8'd10, 9'd2, 1'b0, 1'b0);
        send(2'b01, 2'd0, 2'd1, 2'd0, 2'd0);
        i = 0;
        while (!bus.rsp_valid && i < 200) begin
            @(negedge clk);
            i++;
        end
        push_chk("stall_rsp_seen", int'(bus.rsp_valid), 1);
        bus.req_item  = 2'b10;
        bus.req_ntd50 = 2'd1;
        bus.req_ntd10 = 2'd0;
        bus.req_ntd5  = 2'd0;
        bus.req_ntd1  = 2'd0;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_chk("stall_req_ready",  int'(bus.req_ready), 0);
            push_chk("stall_rsp_valid",  int'(bus.rsp_valid), 1);
            push_chk("stall_rsp_item",   int'(bus.rsp_item), 1);
            push_chk("stall_rsp_change", int'(bus.rsp_change), 2);
            push_chk("stall_rsp_paid",   int'(bus.rsp_paid), 10);
            @(negedge clk);
        end
        set_ret(2'b10, 3'd0, 3'd3, 3'd1, 3'd0);
        expect_rsp(2'b10, 8'd50, 9'd35, 1'b0, 1'b0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        push_chk("after_hs_req_ready", int'(bus.req_ready), 1);
        push_chk("after_hs_rsp_valid", int'(bus.rsp_valid), 0);
        @(negedge clk);
        push_chk("second_accepted", int'(bus.req_ready), 0);
        bus.req_valid = 1'b0;
        drain("drain_backpressure");

        // Reset in WAIT_OFF aborts with no response
        m_mode = 1;
        base = issue_cycles;
        send(2'b01, 2'd0, 2'd1, 2'd0, 2'd0);
        i = 0;
        while (issue_cycles == base && i < 200) begin
            @(negedge clk);
            i++;
        end
        push_chk("reset_test_issued", issue_cycles - base, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_chk("midreset_req_ready", int'(bus.req_ready), 1);
        push_chk("midreset_rsp_valid", int'(bus.rsp_valid), 0);
        push_chk("midreset_item_in",   int'(itemTypeIn), 0);
        push_chk("midreset_coin_in",   int'({coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1}), 0);
        m_mode = 0;
        m_gen++;
        repeat (80) @(negedge clk);
        push_chk("midreset_no_rsp", int'(bus.rsp_valid), 0);

        // Recovery after reset: C for 50, change 28
        set_ret(2'b11, 3'd0, 3'd2, 3'd1, 3'd3);
        expect_rsp(2'b11, 8'd50, 9'd28, 1'b0, 1'b0);
        send(2'b11, 2'd1, 2'd0, 2'd0, 2'd0);
        drain("drain_recovery");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
